// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle controller.
// Provides the opcode encodings, the FSM state type, ALU operation codes and
// the datapath mux-select constants used by the controller and its timer.
package ctrl_pkg;

  // Opcodes, ins[31:26]
  localparam logic [5:0] OP_ROLV = 6'b000000;
  localparam logic [5:0] OP_RORV = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_NOT  = 6'b000100;
  localparam logic [5:0] OP_JR   = 6'b001000;
  localparam logic [5:0] OP_NORI = 6'b001110;
  localparam logic [5:0] OP_BLEU = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b100000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_NOR  = 6'b100110;
  localparam logic [5:0] OP_SW   = 6'b101011;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_AND  = 5'd1;
  localparam logic [4:0] ALU_NOR  = 5'd2;
  localparam logic [4:0] ALU_ROL  = 5'd3;
  localparam logic [4:0] ALU_ROR  = 5'd4;
  localparam logic [4:0] ALU_SLEU = 5'd5;

  // Datapath mux selects
  localparam logic       SRCA_PC       = 1'b0;
  localparam logic       SRCA_RS       = 1'b1;
  localparam logic [1:0] SRCB_RT       = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_SIMM     = 2'd2;
  localparam logic [1:0] SRCB_ZIMM     = 2'd3;
  localparam logic [1:0] PC_SRC_ALU    = 2'd0;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
  localparam logic [1:0] PC_SRC_RS     = 2'd3;
  localparam logic [1:0] DST_RT        = 2'd0;
  localparam logic [1:0] DST_RD        = 2'd1;
  localparam logic [1:0] DST_R31       = 2'd2;
  localparam logic [1:0] WB_ALUOUT     = 2'd0;
  localparam logic [1:0] WB_MDR        = 2'd1;
  localparam logic [1:0] WB_PC         = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JR_EX, S_JAL_EX, S_TRAP
  } state_t;

  // States that hold a memory request open (and are subject to the timeout).
  function automatic logic is_mem_state(state_t s);
    return s inside {S_FETCH, S_MEM_RD, S_MEM_WR};
  endfunction

  // ALU function for the register-register group; NOT is NOR against rt.
  function automatic logic [4:0] r_alu_op(logic [5:0] op);
    case (op)
      OP_AND:         return ALU_AND;
      OP_NOR, OP_NOT: return ALU_NOR;
      OP_ROLV:        return ALU_ROL;
      OP_RORV:        return ALU_ROR;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the multi-cycle controller and the datapath.
// master: controller (reads ins/aluZero/memReady, drives all strobes).
// slave:  datapath/memory side.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             aluZero;
  logic             memReady;
  logic             memReq;
  logic             memRead;
  logic             memWrite;
  logic             iorD;
  logic             irWrite;
  logic             pcWrite;
  logic             pcWriteCond;
  logic [1:0]       pcSource;
  logic             aluSrcA;
  logic [1:0]       aluSrcB;
  logic [4:0]       aluOp;
  logic             regWriteEnable;
  logic [1:0]       regDst;
  logic [1:0]       wbSel;
  logic             retire;
  logic [CNT_W-1:0] retiredCount;
  logic             trap;
  logic             trapCause;

  modport master (
    input  ins, aluZero, memReady,
    output memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
           pcSource, aluSrcA, aluSrcB, aluOp, regWriteEnable, regDst, wbSel,
           retire, retiredCount, trap, trapCause
  );

  modport slave (
    output ins, aluZero, memReady,
    input  memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond,
           pcSource, aluSrcA, aluSrcB, aluOp, regWriteEnable, regDst, wbSel,
           retire, retiredCount, trap, trapCause
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Memory wait-state counter.
// Ports: clk, reset (async, active-high); active = a request is open;
// ready = memory completes this cycle; timeout = this is the TIMEOUT-th
// consecutive wait cycle and memory still has not answered.
module mem_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic ready,
  output logic timeout
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q, count_d;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    count_d = '0;
    // Any cycle without an open, unanswered request clears the count, so each
    // memory state is entered with a fresh count.
    if (active && !ready) count_d = count_q + CW'(1);
  end

  // A ready on the last allowed cycle still wins over the timeout.
  assign timeout = active && !ready && (count_q == CW'(TIMEOUT - 1));

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control FSM for a shared ALU / unified memory datapath.
// Ports: clk, reset (async, active-high), bus (master side of
// multicycle_control_if: instruction, memory handshake, datapath strobes,
// retire pulse and counter, sticky trap with cause).
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  state_t           state_q, state_d;
  logic             trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] retired_count_q, retired_count_d;
  logic             retire;
  logic             timeout;
  logic [5:0]       opcode;

  assign opcode = bus.ins[31:26];

  // Only the opcode field is decoded; aluZero is consumed by the PC logic.
  logic unused_ok;
  assign unused_ok = ^{bus.ins[25:0], bus.aluZero};

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .active  (is_mem_state(state_q) && !reset),
    .ready   (bus.memReady),
    .timeout (timeout)
  );

  always_comb begin
    state_d            = state_q;
    trap_cause_d       = trap_cause_q;
    retire             = 1'b0;
    bus.memReq         = 1'b0;
    bus.memRead        = 1'b0;
    bus.memWrite       = 1'b0;
    bus.iorD           = 1'b0;
    bus.irWrite        = 1'b0;
    bus.pcWrite        = 1'b0;
    bus.pcWriteCond    = 1'b0;
    bus.pcSource       = PC_SRC_ALU;
    bus.aluSrcA        = SRCA_PC;
    bus.aluSrcB        = SRCB_RT;
    bus.aluOp          = ALU_ADD;
    bus.regWriteEnable = 1'b0;
    bus.regDst         = DST_RT;
    bus.wbSel          = WB_ALUOUT;

    // Strobes are forced low while reset is held, so an in-flight access is
    // dropped without waiting for a clock edge.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          bus.memReq  = 1'b1;
          bus.memRead = 1'b1;
          if (bus.memReady) begin
            bus.irWrite = 1'b1;
            bus.pcWrite = 1'b1;
            bus.aluSrcB = SRCB_FOUR;
            state_d     = S_DECODE;
          end else if (timeout) begin
            state_d      = S_TRAP;
            trap_cause_d = 1'b1;
          end
        end
        S_DECODE: begin
          bus.aluSrcB = SRCB_SIMM;
          case (opcode)
            OP_LW, OP_SW:                             state_d = S_MEM_ADDR;
            OP_AND, OP_NOR, OP_NOT, OP_ROLV, OP_RORV: state_d = S_R_EXEC;
            OP_NORI:                                  state_d = S_I_EXEC;
            OP_BLEU:                                  state_d = S_BRANCH;
            OP_JR:                                    state_d = S_JR_EX;
            OP_JAL:                                   state_d = S_JAL_EX;
            default: begin
              state_d      = S_TRAP;
              trap_cause_d = 1'b0;
            end
          endcase
        end
        S_MEM_ADDR: begin
          bus.aluSrcA = SRCA_RS;
          bus.aluSrcB = SRCB_SIMM;
          state_d     = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
        S_MEM_RD, S_MEM_WR: begin
          bus.memReq   = 1'b1;
          bus.memRead  = (state_q == S_MEM_RD);
          bus.memWrite = (state_q == S_MEM_WR);
          bus.iorD     = 1'b1;
          if (bus.memReady) begin
            if (state_q == S_MEM_RD) begin
              state_d = S_MEM_WB;
            end else begin
              retire  = 1'b1;
              state_d = S_FETCH;
            end
          end else if (timeout) begin
            state_d      = S_TRAP;
            trap_cause_d = 1'b1;
          end
        end
        S_MEM_WB: begin
          bus.regWriteEnable = 1'b1;
          bus.wbSel          = WB_MDR;
          retire             = 1'b1;
          state_d            = S_FETCH;
        end
        S_R_EXEC: begin
          bus.aluSrcA = SRCA_RS;
          bus.aluOp   = r_alu_op(opcode);
          state_d     = S_R_WB;
        end
        S_I_EXEC: begin
          bus.aluSrcA = SRCA_RS;
          bus.aluSrcB = SRCB_ZIMM;
          bus.aluOp   = ALU_NOR;
          state_d     = S_I_WB;
        end
        S_R_WB, S_I_WB: begin
          bus.regWriteEnable = 1'b1;
          bus.regDst         = (state_q == S_R_WB) ? DST_RD : DST_RT;
          retire             = 1'b1;
          state_d            = S_FETCH;
        end
        S_BRANCH: begin
          bus.aluSrcA     = SRCA_RS;
          bus.aluOp       = ALU_SLEU;
          bus.pcWriteCond = 1'b1;
          bus.pcSource    = PC_SRC_ALUOUT;
          retire          = 1'b1;
          state_d         = S_FETCH;
        end
        S_JR_EX: begin
          bus.pcWrite  = 1'b1;
          bus.pcSource = PC_SRC_RS;
          retire       = 1'b1;
          state_d      = S_FETCH;
        end
        S_JAL_EX: begin
          bus.regWriteEnable = 1'b1;
          bus.regDst         = DST_R31;
          bus.wbSel          = WB_PC;
          bus.pcWrite        = 1'b1;
          bus.pcSource       = PC_SRC_JUMP;
          retire             = 1'b1;
          state_d            = S_FETCH;
        end
        default: ;  // S_TRAP: everything held low until reset
      endcase
    end
  end

  always_comb retired_count_d = retired_count_q + {{(CNT_W-1){1'b0}}, retire};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_FETCH;
      trap_cause_q    <= 1'b0;
      retired_count_q <= '0;
    end else begin
      state_q         <= state_d;
      trap_cause_q    <= trap_cause_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign bus.retire       = retire;
  assign bus.retiredCount = retired_count_q;
  assign bus.trap         = (state_q == S_TRAP);
  assign bus.trapCause    = trap_cause_q;
endmodule
